// File: rtl/kcomb_pattern_gen.sv
// Popcount-to-pattern generator: after a load of count n, streams every W-bit
// word with exactly n bits set, in ascending order, over a valid/ready port.
module kcomb_pattern_gen #(
  parameter int W  = 8,
  parameter int CW = 4,
  parameter int IW = 7
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_load,
  input  logic [CW-1:0] i_n,
  input  logic          i_out_ready,
  output logic          o_busy,
  output logic [W-1:0]  o_q,
  output logic          o_out_valid,
  output logic          o_last,
  output logic [IW-1:0] o_idx,
  output logic          o_err,
  output logic          o_state
);

  // Output handshake: a word moves when o_out_valid && i_out_ready at a rising
  // edge; while o_out_valid is high and i_out_ready low, o_q/o_last/o_idx hold.
  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t        r_state;
  logic [W-1:0]  r_q;
  logic [W-1:0]  r_top;
  logic          r_valid;
  logic          r_last;
  logic [IW-1:0] r_idx;
  logic          r_err;
  logic          r_busy;

  logic [W:0]    w_q_ext;
  logic [W:0]    w_c;
  logic [W:0]    w_r;
  logic [W-1:0]  w_succ;
  logic          w_xfer;
  logic          w_n_bad;

  function automatic logic [W-1:0] low_mask(input logic [CW-1:0] n);
    logic [W-1:0] m;
    m = '0;
    for (int i = 0; i < W; i++) m[i] = (i < int'(n));
    return m;
  endfunction

  // Highest word of the sequence: the n set bits packed against the MSB.
  function automatic logic [W-1:0] top_mask(input logic [CW-1:0] n);
    logic [W-1:0] m;
    m = '0;
    for (int i = 0; i < W; i++) m[i] = (i >= (W - int'(n)));
    return m;
  endfunction

  function automatic int ctz(input logic [W:0] c);
    int k;
    k = 0;
    for (int i = W; i >= 0; i--) if (c[i]) k = i;
    return k;
  endfunction

  // Gosper step in W+1 bits so the carry out of the lowest run is kept.
  always_comb begin
    w_q_ext = {1'b0, r_q};
    w_c     = w_q_ext & (~w_q_ext + 1'b1);
    w_r     = w_q_ext + w_c;
    w_succ  = W'(w_r | (((w_r ^ w_q_ext) >> 2) >> ctz(w_c)));
  end

  assign w_xfer  = r_valid && i_out_ready;
  assign w_n_bad = (i_n > CW'(W));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_q     <= '0;
      r_top   <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_idx   <= '0;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_load) begin
            if (w_n_bad) begin
              r_err <= 1'b1;
            end else begin
              r_state <= S_RUN;
              r_q     <= low_mask(i_n);
              r_top   <= top_mask(i_n);
              r_valid <= 1'b1;
              r_last  <= (i_n == '0) || (i_n == CW'(W));
              r_idx   <= '0;
              r_busy  <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (w_xfer) begin
            if (r_last) begin
              r_state <= S_IDLE;
              r_valid <= 1'b0;
              r_last  <= 1'b0;
              r_busy  <= 1'b0;
            end else begin
              r_q    <= w_succ;
              r_idx  <= r_idx + 1'b1;
              r_last <= (w_succ == r_top);
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_busy      = r_busy;
  assign o_q         = r_q;
  assign o_out_valid = r_valid;
  assign o_last      = r_last;
  assign o_idx       = r_idx;
  assign o_err       = r_err;
  assign o_state     = r_state;

endmodule

// File: tb/tb_kcomb_pattern_gen.sv
// Bench for kcomb_pattern_gen: expected words come from enumerating all 8-bit
// values by popcount; a monitor pops and compares every transferred word.
module tb_kcomb_pattern_gen;

  localparam int W  = 8;
  localparam int CW = 4;
  localparam int IW = 7;
  localparam int EW = IW + 1 + W;

  logic          clk;
  logic          rst;
  logic          load;
  logic [CW-1:0] n_in;
  logic          out_ready;
  logic          busy;
  logic [W-1:0]  q;
  logic          out_valid;
  logic          last;
  logic [IW-1:0] idx;
  logic          err;
  logic          state;

  logic [EW-1:0] exp_q[$];
  int            n_checks;
  int            n_fail;
  logic          check_pop3;

  kcomb_pattern_gen #(.W(W), .CW(CW), .IW(IW)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_load      (load),
    .i_n         (n_in),
    .i_out_ready (out_ready),
    .o_busy      (busy),
    .o_q         (q),
    .o_out_valid (out_valid),
    .o_last      (last),
    .o_idx       (idx),
    .o_err       (err),
    .o_state     (state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic int ones_count(input logic [W-1:0] v);
    int c;
    c = 0;
    for (int i = 0; i < W; i++) c += int'(v[i]);
    return c;
  endfunction

  // Reference: all words with popcount n in ascending order.
  task automatic push_expected(input int n, output logic [W-1:0] last_w, output int cnt);
    logic [W-1:0]  words[$];
    logic [W-1:0]  v;
    logic [IW-1:0] ii;
    for (int k = 0; k < (1 << W); k++) begin
      v = k[W-1:0];
      if (ones_count(v) == n) words.push_back(v);
    end
    cnt = words.size();
    for (int i = 0; i < cnt; i++) begin
      ii = i[IW-1:0];
      exp_q.push_back({ii, (i == cnt - 1), words[i]});
    end
    last_w = words[cnt - 1];
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic          prev_stall;
  logic [EW-1:0] prev_word;
  logic [W-1:0]  prev_acc_q;
  logic [EW-1:0] exp_w;

  initial begin
    prev_stall = 1'b0;
    prev_word  = '0;
    prev_acc_q = '0;
    forever begin
      @(negedge clk);
      if (!rst && out_valid) begin
        if (prev_stall) check("stall_hold", {16'h0, idx, last, q}, {16'h0, prev_word});
        if (out_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_word", {16'h0, idx, last, q}, 32'hFFFF_FFFF);
          end else begin
            exp_w = exp_q.pop_front();
            check("word", {16'h0, idx, last, q}, {16'h0, exp_w});
            if (check_pop3) begin
              check("popcount3", ones_count(q), 3);
              if (idx != 0) check("increasing", 32'(q > prev_acc_q), 1);
            end
          end
          prev_acc_q = q;
        end
        prev_stall = !out_ready;
        prev_word  = {idx, last, q};
        if (busy) check("err_in_run", 32'(err), 0);
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  // ---------------- driver ----------------
  task automatic run_seq(input int n, input bit rnd);
    logic [W-1:0] last_w;
    int           cnt;
    int           cyc;
    push_expected(n, last_w, cnt);
    load      = 1'b1;
    n_in      = n[CW-1:0];
    out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    tick;
    load = 1'b0;
    check("first_valid", 32'(out_valid), 1);
    check("first_busy", 32'(busy), 1);
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 4000) begin
      if (rnd) begin
        out_ready = 1'($urandom_range(0, 1));
        load      = ($urandom_range(0, 3) == 0);
        n_in      = 4'($urandom_range(0, 15));
      end
      tick;
      cyc++;
    end
    load = 1'b0;
    if (cyc >= 4000) begin
      check("timeout", 32'(exp_q.size()), 0);
      exp_q.delete();
    end
    check("end_valid", 32'(out_valid), 0);
    check("end_busy", 32'(busy), 0);
    check("end_q", 32'(q), 32'(last_w));
    check("end_idx", 32'(idx), 32'(cnt - 1));
    out_ready = 1'b1;
    tick;
  endtask

  initial begin
    logic [W-1:0] lw;
    int           cnt;
    int           cyc;
    n_checks   = 0;
    n_fail     = 0;
    check_pop3 = 1'b0;
    rst        = 1'b1;
    load       = 1'b1;
    n_in       = 4'd4;
    out_ready  = 1'b0;
    tick;
    tick;
    rst  = 1'b0;
    load = 1'b0;
    check("rst_valid", 32'(out_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_q", 32'(q), 0);
    check("rst_idx", 32'(idx), 0);
    check("rst_last", 32'(last), 0);
    check("rst_err", 32'(err), 0);
    check("rst_state", 32'(state), 0);
    tick;
    check("rst_load_ignored", 32'(busy), 0);

    run_seq(1, 1'b0);
    run_seq(2, 1'b0);
    run_seq(0, 1'b0);
    run_seq(8, 1'b0);

    for (int k = 9; k < 16; k++) begin
      load = 1'b1;
      n_in = k[CW-1:0];
      tick;
      load = 1'b0;
      check("err_pulse", 32'(err), 1);
      check("err_valid", 32'(out_valid), 0);
      check("err_busy", 32'(busy), 0);
      tick;
      check("err_clear", 32'(err), 0);
    end

    // Load held through the final transfer is only taken one cycle later.
    push_expected(0, lw, cnt);
    push_expected(0, lw, cnt);
    load      = 1'b1;
    n_in      = 4'd0;
    out_ready = 1'b1;
    tick;
    check("hold_first", 32'(out_valid), 1);
    tick;
    check("hold_gap", 32'(out_valid), 0);
    tick;
    check("hold_reload", 32'(out_valid), 1);
    load = 1'b0;
    tick;
    check("hold_done", 32'(out_valid), 0);
    check("hold_queue", 32'(exp_q.size()), 0);
    exp_q.delete();

    check_pop3 = 1'b1;
    run_seq(3, 1'b1);
    check_pop3 = 1'b0;

    // Reset in the middle of an n = 4 run.
    push_expected(4, lw, cnt);
    load      = 1'b1;
    n_in      = 4'd4;
    out_ready = 1'b1;
    tick;
    load = 1'b0;
    cyc  = 0;
    while (idx != 7'd10 && cyc < 200) begin
      tick;
      cyc++;
    end
    check("reach_idx10", 32'(idx), 10);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    exp_q.delete();
    check("midrst_valid", 32'(out_valid), 0);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_q", 32'(q), 0);
    check("midrst_idx", 32'(idx), 0);
    check("midrst_last", 32'(last), 0);
    check("midrst_state", 32'(state), 0);
    tick;
    check("midrst_quiet", 32'(out_valid), 0);

    load = 1'b1;
    n_in = 4'd4;
    tick;
    load = 1'b0;
    check("restart_q", 32'(q), 32'h0F);
    check("restart_idx", 32'(idx), 0);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    tick;
    run_seq(4, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
